// File: rtl/display_map_writer_if.sv
// Feature-map activation stream into display_map_writer (AXI-Stream subset).
interface display_map_writer_if #(
  parameter int IN_W = 16
);
  logic signed [IN_W-1:0] s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [4:0]             s_tuser;

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser,
    input  s_tready
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser,
    output s_tready
  );
endinterface

// File: rtl/display_map_writer.sv
// Writes quantised CNN feature maps into the display BRAM at each tile's base
// address, checking map length and tile ID and flagging map/frame completion.
module display_map_writer #(
  parameter int NM    = 22,
  parameter int IN_W  = 16,
  parameter int SHIFT = 4,
  parameter int AW    = 16
) (
  input  logic                 pix_clk,
  input  logic                 rst_n,
  display_map_writer_if.slave  s,
  input  logic                 freeze,
  input  logic                 err_clr,
  output logic [AW-1:0]        bram_addr,
  output logic [7:0]           bram_wdata,
  output logic                 bram_we,
  output logic                 map_done,
  output logic [4:0]           map_id,
  output logic                 frame_done,
  output logic                 err_len,
  output logic                 err_tile
);

  typedef enum logic [1:0] {IDLE, STREAM, SKIP} state_t;

  state_t        state_q, state_d;
  logic          rdy_q;
  logic [4:0]    tile_q, tile_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] size_q, size_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          take;
  logic          tile_ok;
  logic [AW-1:0] first_base, first_size;

  logic          we_d, done_d, len_err_d, tile_err_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    wdata_d;
  logic [4:0]    id_d;

  logic          we_p1, done_p1, frame_p1;
  logic [AW-1:0] addr_p1;
  logic [7:0]    wdata_p1;
  logic [4:0]    id_p1;
  logic          err_len_q, err_tile_q;

  function automatic logic [7:0] quant(input logic signed [IN_W-1:0] d);
    logic signed [IN_W-1:0] q;
    q = d >>> SHIFT;
    if (q[IN_W-1])
      return 8'd0;
    else if (q > $signed(IN_W'(255)))
      return 8'hFF;
    else
      return q[7:0];
  endfunction

  function automatic logic [AW-1:0] tile_base(input logic [4:0] t);
    if (t == 5'd0)
      return '0;
    else if (t <= 5'd16)
      return AW'(16'h0320) + AW'(t - 5'd1) * AW'(16'h0240);
    else if (t <= 5'd20)
      return AW'(16'h2720) + AW'(t - 5'd17) * AW'(16'h0040);
    else
      return AW'(16'h2820);
  endfunction

  function automatic logic [AW-1:0] tile_size(input logic [4:0] t);
    if (t == 5'd0)
      return AW'(784);
    else if (t <= 5'd16)
      return AW'(576);
    else if (t <= 5'd20)
      return AW'(64);
    else
      return AW'(10);
  endfunction

  // freeze only blocks the start of a new map; maps in flight always finish
  assign s.s_tready  = rdy_q & ~((state_q == IDLE) & freeze);
  assign take        = s.s_tvalid & s.s_tready;
  assign tile_ok     = int'(s.s_tuser) < NM;
  assign first_base  = tile_base(s.s_tuser);
  assign first_size  = tile_size(s.s_tuser);

  // State, ready and beat-counter register
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

  // Per-map tile descriptor, only meaningful while streaming
  always_ff @(posedge pix_clk) begin
    tile_q <= tile_d;
    base_q <= base_d;
    size_q <= size_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (take) begin
      unique case (state_q)
        IDLE: begin
          if (s.s_tlast)
            state_d = IDLE;
          else if (tile_ok)
            state_d = STREAM;
          else
            state_d = SKIP;
        end
        STREAM: begin
          if (s.s_tlast)
            state_d = IDLE;
          else if (cnt_q == size_q)
            state_d = SKIP;
        end
        SKIP: begin
          if (s.s_tlast)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath decisions for the accepted beat
  always_comb begin
    we_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = quant(s.s_tdata);
    done_d     = 1'b0;
    id_d       = '0;
    len_err_d  = 1'b0;
    tile_err_d = 1'b0;
    cnt_d      = cnt_q;
    tile_d     = tile_q;
    base_d     = base_q;
    size_d     = size_q;
    if (take) begin
      unique case (state_q)
        IDLE: begin
          if (tile_ok) begin
            tile_d = s.s_tuser;
            base_d = first_base;
            size_d = first_size;
            cnt_d  = AW'(1);
            we_d   = 1'b1;
            addr_d = first_base;
            if (s.s_tlast) begin
              if (first_size == AW'(1)) begin
                done_d = 1'b1;
                id_d   = s.s_tuser;
              end else begin
                len_err_d = 1'b1;
              end
            end
          end else begin
            tile_err_d = 1'b1;
          end
        end
        STREAM: begin
          if (cnt_q < size_q) begin
            we_d   = 1'b1;
            addr_d = base_q + cnt_q;
            cnt_d  = cnt_q + AW'(1);
            if (s.s_tlast) begin
              if (cnt_q + AW'(1) == size_q) begin
                done_d = 1'b1;
                id_d   = tile_q;
              end else begin
                len_err_d = 1'b1;
              end
            end
          end else begin
            len_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered BRAM write, completion pulses, sticky errors ----
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      we_p1      <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      done_p1    <= 1'b0;
      id_p1      <= '0;
      frame_p1   <= 1'b0;
      err_len_q  <= 1'b0;
      err_tile_q <= 1'b0;
    end else begin
      we_p1      <= we_d;
      addr_p1    <= we_d ? addr_d : '0;
      wdata_p1   <= we_d ? wdata_d : '0;
      done_p1    <= done_d;
      id_p1      <= id_d;
      frame_p1   <= done_d & (id_d == 5'(NM - 1));
      err_len_q  <= len_err_d  | (err_len_q  & ~err_clr);
      err_tile_q <= tile_err_d | (err_tile_q & ~err_clr);
    end
  end

  assign bram_we    = we_p1;
  assign bram_addr  = addr_p1;
  assign bram_wdata = wdata_p1;
  assign map_done   = done_p1;
  assign map_id     = id_p1;
  assign frame_done = frame_p1;
  assign err_len    = err_len_q;
  assign err_tile   = err_tile_q;

endmodule

// File: tb/tb_display_map_writer.sv
// Randomised bench for display_map_writer with a map-level reference model.
module tb_display_map_writer;
  localparam int NM = 22, IN_W = 16, SHIFT = 4, AW = 16;

  logic pix_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic freeze  = 1'b0;
  logic err_clr = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_wdata;
  logic          bram_we, map_done, frame_done, err_len, err_tile;
  logic [4:0]    map_id;

  always #5 pix_clk = ~pix_clk;

  display_map_writer_if #(.IN_W(IN_W)) s_if ();

  display_map_writer #(.NM(NM), .IN_W(IN_W), .SHIFT(SHIFT), .AW(AW)) dut (
    .pix_clk    (pix_clk),
    .rst_n      (rst_n),
    .s          (s_if.slave),
    .freeze     (freeze),
    .err_clr    (err_clr),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_we    (bram_we),
    .map_done   (map_done),
    .map_id     (map_id),
    .frame_done (frame_done),
    .err_len    (err_len),
    .err_tile   (err_tile)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: record every write and completion pulse
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          done_n, frame_n;
  logic [4:0]  done_id;
  logic        done_we;
  logic [15:0] done_addr;

  always @(negedge pix_clk) begin
    if (bram_we) begin
      wr_addr_q.push_back(bram_addr);
      wr_data_q.push_back(bram_wdata);
    end
    if (map_done) begin
      done_n++;
      done_id   = map_id;
      done_we   = bram_we;
      done_addr = bram_addr;
    end
    if (frame_done) frame_n++;
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_n = 0;
    frame_n = 0;
    done_id = '0;
    done_we = 1'b0;
    done_addr = '0;
  endtask

  // Reference: tile layout and quantisation rule
  function automatic int ref_base(input int t);
    if (t == 0) return 0;
    if (t <= 16) return 'h320 + (t - 1) * 'h240;
    if (t <= 20) return 'h2720 + (t - 17) * 'h40;
    return 'h2820;
  endfunction

  function automatic int ref_size(input int t);
    if (t == 0) return 784;
    if (t <= 16) return 576;
    if (t <= 20) return 64;
    return 10;
  endfunction

  function automatic int ref_quant(input logic [15:0] d);
    int v;
    v = int'($signed(d)) >>> SHIFT;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  logic [15:0] beat_d[$];
  bit exp_len  = 1'b0;
  bit exp_tile = 1'b0;
  int freeze_at = -1;

  task automatic fill_const(input int n, input logic [15:0] v);
    beat_d.delete();
    for (int i = 0; i < n; i++) beat_d.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    beat_d.delete();
    for (int i = 0; i < n; i++) beat_d.push_back(16'($urandom));
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic [4:0] u, input logic l, input int gap);
    int t;
    while (int'($urandom_range(99)) < gap) begin
      @(negedge pix_clk);
      s_if.s_tvalid = 1'b0;
      s_if.s_tdata  = 16'($urandom);
      s_if.s_tuser  = 5'($urandom);
      s_if.s_tlast  = 1'($urandom);
    end
    @(negedge pix_clk);
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = d;
    s_if.s_tuser  = u;
    s_if.s_tlast  = l;
    #1;
    t = 0;
    while (!s_if.s_tready && t < 200) begin
      @(negedge pix_clk);
      #1;
      t++;
    end
    if (t == 200) chk("tready_timeout", 32'd0, 32'd1);
    @(posedge pix_clk);
  endtask

  task automatic run_map(input int tile, input int gap);
    int n, sz, nw, base;
    bit valid, exp_done;
    clear_mon();
    n = beat_d.size();
    for (int i = 0; i < n; i++) begin
      if (i == freeze_at) freeze = 1'b1;
      drive_beat(beat_d[i], (i == 0) ? 5'(tile) : 5'($urandom), i == n - 1, gap);
    end
    @(negedge pix_clk);
    s_if.s_tvalid = 1'b0;
    repeat (3) @(negedge pix_clk);
    #1;
    valid = tile < NM;
    sz    = ref_size(tile);
    base  = ref_base(tile);
    nw    = valid ? ((n < sz) ? n : sz) : 0;
    chk($sformatf("wr_count_t%0d", tile), wr_addr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      chk($sformatf("addr_t%0d_b%0d", tile, i), wr_addr_q[i], base + i);
      chk($sformatf("data_t%0d_b%0d", tile, i), wr_data_q[i], ref_quant(beat_d[i]));
    end
    exp_done = valid && (n == sz);
    chk($sformatf("done_count_t%0d", tile), done_n, exp_done);
    if (exp_done) begin
      chk("done_id", done_id, tile);
      chk("done_with_last_write", {done_we, done_addr}, {1'b1, 16'(base + sz - 1)});
    end
    chk($sformatf("frame_count_t%0d", tile), frame_n, (exp_done && tile == NM - 1) ? 1 : 0);
    if (valid && n != sz) exp_len = 1'b1;
    if (!valid) exp_tile = 1'b1;
    chk("err_len", err_len, exp_len);
    chk("err_tile", err_tile, exp_tile);
  endtask

  task automatic clear_errs();
    @(negedge pix_clk);
    err_clr = 1'b1;
    @(negedge pix_clk);
    err_clr = 1'b0;
    #1;
    exp_len  = 1'b0;
    exp_tile = 1'b0;
    chk("err_len_cleared", err_len, 1'b0);
    chk("err_tile_cleared", err_tile, 1'b0);
  endtask

  initial begin
    int tile, n, sz;
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 16'h1234;
    s_if.s_tuser  = 5'd3;
    s_if.s_tlast  = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) @(posedge pix_clk);
    @(negedge pix_clk);
    chk("rst_we", bram_we, 1'b0);
    chk("rst_addr", bram_addr, 16'h0);
    chk("rst_wdata", bram_wdata, 8'h0);
    chk("rst_done", {map_done, map_id, frame_done}, 7'h0);
    chk("rst_errs", {err_len, err_tile}, 2'b00);
    chk("rst_tready", s_if.s_tready, 1'b0);
    rst_n = 1'b1;
    s_if.s_tvalid = 1'b0;
    #1;
    chk("tready_before_first_edge", s_if.s_tready, 1'b0);
    @(negedge pix_clk);
    chk("tready_after_reset", s_if.s_tready, 1'b1);

    // Constant map into a conv2 tile
    fill_const(64, 16'h0123);
    run_map(17, 0);

    // Quantisation corners on the probability bar (frame completion)
    fill_rand(10);
    beat_d[0] = 16'hFF00; beat_d[1] = 16'h0FF0; beat_d[2] = 16'h1000;
    beat_d[3] = 16'h7FFF; beat_d[4] = 16'h0010; beat_d[5] = 16'h8000;
    beat_d[6] = 16'h000F; beat_d[7] = 16'hFFFF;
    run_map(21, 20);

    // Long conv1 map with bursty valid
    fill_rand(576);
    run_map(5, 30);

    // Early tlast
    fill_rand(30);
    run_map(0, 10);
    clear_errs();

    // Overflow
    fill_rand(12);
    run_map(21, 10);
    clear_errs();

    // Bad tile ID
    fill_rand(5);
    run_map(25, 10);
    clear_errs();

    // Freeze raised mid-map: map still finishes, then new maps are held off
    fill_rand(576);
    freeze_at = 100;
    run_map(1, 5);
    freeze_at = -1;
    clear_mon();
    @(negedge pix_clk);
    s_if.s_tvalid = 1'b1;
    s_if.s_tuser  = 5'd17;
    s_if.s_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("tready_frozen", s_if.s_tready, 1'b0);
      @(negedge pix_clk);
    end
    #1;
    chk("no_writes_frozen", wr_addr_q.size(), 0);
    freeze = 1'b0;
    s_if.s_tvalid = 1'b0;
    fill_rand(64);
    run_map(18, 10);

    // Random maps around the nominal length
    for (int k = 0; k < 10; k++) begin
      tile = ($urandom_range(5) == 0) ? int'($urandom_range(31, NM)) : int'($urandom_range(21, 17));
      sz = ref_size(tile);
      n = (tile < NM) ? sz + int'($urandom_range(2)) - 1 : int'($urandom_range(6, 1));
      fill_rand(n);
      run_map(tile, 25);
      if (exp_len || exp_tile) clear_errs();
    end

    // Reset in the middle of a map
    clear_mon();
    fill_rand(10);
    for (int i = 0; i < 10; i++) drive_beat(beat_d[i], (i == 0) ? 5'd19 : 5'($urandom), 1'b0, 0);
    @(negedge pix_clk);
    s_if.s_tvalid = 1'b1;
    rst_n = 1'b0;
    @(negedge pix_clk);
    #1;
    chk("midreset_no_write", bram_we, 1'b0);
    chk("midreset_tready", s_if.s_tready, 1'b0);
    chk("midreset_writes", wr_addr_q.size(), 10);
    s_if.s_tvalid = 1'b0;
    rst_n = 1'b1;
    exp_len = 1'b0;
    exp_tile = 1'b0;
    @(negedge pix_clk);
    fill_rand(64);
    run_map(19, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0 want=1");
    $fatal(1, "timeout");
  end
endmodule
